// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out
// reads and writer requests; scan-out owns phase-0 cycles of each 4x4 pixel.
// Revision: 1.0
// ============================================================================
module vga_fb_arbiter #(
    parameter int FB_W = 256,
    parameter int FB_H = 192
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic [9:0]  hc_visible,
    input  logic [9:0]  vc_visible,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pix_data,
    output logic        hs_out,
    output logic        vs_out
);

    localparam logic [16:0] C_FB_SIZE = 17'(FB_W * FB_H);
    localparam logic [10:0] C_FB_W    = 11'(FB_W);
    localparam logic [10:0] C_FB_H    = 11'(FB_H);

    logic [9:0]  w_hm1;
    logic [9:0]  w_col;
    logic [9:0]  w_row;
    logic [15:0] w_rd_addr;
    logic        w_visible;
    logic        w_slot;
    logic        w_write;
    logic        w_in_range;

    logic        wr_ack_q, wr_ack_d;
    logic [15:0] addr_q, addr_d;
    logic        slot_q, slot_d;
    logic [7:0]  pix_q, pix_d;
    logic        vis1_q, vis1_d, vis2_q, vis2_d;
    logic        hs1_q, hs1_d, hs2_q, hs2_d;
    logic        vs1_q, vs1_d, vs2_q, vs2_d;

    always_comb begin
        w_hm1      = hc_visible - 10'd1;
        w_col      = w_hm1 >> 2;
        w_row      = (vc_visible - 10'd1) >> 2;
        w_visible  = (hc_visible != 10'd0) && (vc_visible != 10'd0);
        w_slot     = w_visible && (w_hm1[1:0] == 2'd0) &&
                     ({1'b0, w_row} < C_FB_H) && ({1'b0, w_col} < C_FB_W);
        w_rd_addr  = ({6'd0, w_row} * 16'(FB_W)) + {6'd0, w_col};
        w_in_range = ({1'b0, wr_addr} < C_FB_SIZE);
        // The ack cycle never writes, so a held request is serviced only once.
        w_write    = !rst && wr_req && !wr_ack_q && !w_slot;
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wr_data;
        wr_ack_d  = 1'b0;
        if (w_slot) begin
            mem_addr = w_rd_addr;
        end else if (w_write) begin
            mem_addr = wr_addr;
            mem_we   = w_in_range;
            wr_ack_d = 1'b1;
        end
        addr_d = mem_addr;
        slot_d = w_slot;
        pix_d  = slot_q ? mem_rdata : pix_q;
        vis1_d = w_visible;
        vis2_d = vis1_q;
        hs1_d  = hs_in;
        hs2_d  = hs1_q;
        vs1_d  = vs_in;
        vs2_d  = vs1_q;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            wr_ack_q <= 1'b0;
            addr_q   <= 16'd0;
            slot_q   <= 1'b0;
            pix_q    <= 8'd0;
            vis1_q   <= 1'b0;
            vis2_q   <= 1'b0;
            hs1_q    <= 1'b1;
            hs2_q    <= 1'b1;
            vs1_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            wr_ack_q <= wr_ack_d;
            addr_q   <= addr_d;
            slot_q   <= slot_d;
            pix_q    <= pix_d;
            vis1_q   <= vis1_d;
            vis2_q   <= vis2_d;
            hs1_q    <= hs1_d;
            hs2_q    <= hs2_d;
            vs1_q    <= vs1_d;
            vs2_q    <= vs2_d;
        end
    end

    assign wr_ack   = wr_ack_q;
    assign pix_data = vis2_q ? pix_q : 8'd0;
    assign hs_out   = hs2_q;
    assign vs_out   = vs2_q;

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter FB_W, default 256, meaning framebuffer width in pixels (1024/4).
REQ-002 SHALL have parameter FB_H, default 192, meaning framebuffer height in pixels (768/4).
REQ-003 SHALL have port clk_vga  input  1  pixel clock, 82 MHz; the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port hc_visible  input  10  horizontal visible counter from the VGA driver; 0 = blanking.
REQ-006 SHALL have port vc_visible  input  10  vertical visible counter from the VGA driver; 0 = blanking.
REQ-007 SHALL have port hs_in, vs_in  input  1 each  sync pulses from the VGA driver.
REQ-008 SHALL have port wr_req  input  1  writer requests one pixel write; held until wr_ack.
REQ-009 SHALL have port wr_addr  input  16  writer pixel address, row*FB_W + column.
REQ-010 SHALL have port wr_data  input  8  writer pixel colour.
REQ-011 SHALL have port wr_ack  output  1  one-cycle pulse: the write was serviced.
REQ-012 SHALL have port mem_addr  output  16  single-port synchronous RAM address.
REQ-013 SHALL have port mem_we  output  1  RAM write enable.
REQ-014 SHALL have port mem_wdata  output  8  RAM write data.
REQ-015 SHALL have port mem_rdata  input  8  RAM read data, valid one cycle after the address.
REQ-016 SHALL have port pix_data  output  8  colour for the current screen pixel.
REQ-017 SHALL have port hs_out, vs_out  output  1 each  hs_in/vs_in aligned to pix_data.

Function
REQ-018 SHALL treat a cycle as visible when hc_visible != 0 and vc_visible != 0.
REQ-019 SHALL compute phase = (hc_visible - 1)[1:0], column = (hc_visible - 1) >> 2, row = (vc_visible - 1) >> 2.
REQ-020 SHALL define a read slot as a visible cycle with phase == 0 and row < FB_H and column < FB_W.
REQ-021 SHALL, in a read slot, drive mem_addr = row*FB_W + column and mem_we = 0, regardless of wr_req.
REQ-022 SHALL capture mem_rdata into a pixel register on the cycle after each read slot.
REQ-023 SHALL drive pix_data from the pixel register with a fixed 2-cycle lag relative to hc_visible, forced to 0 when the visible flag delayed by 2 cycles is low.
REQ-024 SHALL delay hs_in and vs_in by exactly 2 registers to produce hs_out and vs_out.
REQ-025 SHALL, in any non-read-slot cycle with wr_req = 1 and no wr_ack in the previous cycle, drive mem_addr = wr_addr, mem_wdata = wr_data, mem_we = (wr_addr < FB_W*FB_H), and register wr_ack = 1 for the next cycle.
REQ-026 SHALL ack out-of-range writes (wr_addr >= FB_W*FB_H) without asserting mem_we.
REQ-027 SHALL NOT issue two acks for one request: the cycle during which wr_ack = 1 is never a write cycle.
REQ-028 SHALL service a pending write within 2 cycles of wr_req rising (worst case: a read slot, then a write).
REQ-029 SHALL, in cycles that are neither a read slot nor a write, drive mem_we = 0 and hold mem_addr at its last value.
REQ-030 SHALL use 16-bit unsigned arithmetic for all address math, with no wrap.

Reset
REQ-031 SHALL, while rst = 1, clear wr_ack, mem_we, the pixel register, pix_data, both delay stages, and force hs_out = vs_out = 1.
REQ-032 SHALL drop a write that is in progress when rst asserts mid-operation: no wr_ack is issued; the writer re-requests.
REQ-033 SHALL resume the read slots on the first cycle after rst deasserts, with no extra initialisation.

Verification
REQ-034 Reset: rst=1 for 3 cycles with wr_req=1 -> wr_ack=0, mem_we=0, pix_data=0, hs_out=vs_out=1 throughout.
REQ-035 Blanking write: hc_visible=0, wr_req=1, wr_addr=16'h0105, wr_data=8'hA5 -> mem_we=1, mem_addr=16'h0105 in the same cycle, wr_ack=1 the next cycle, then 0.
REQ-036 Collision: wr_req=1 during a read slot at hc_visible=5, vc_visible=9 -> mem_addr=16'h0201 (row 2, column 1), mem_we=0; write at hc_visible=6; ack at 7.
REQ-037 Scan-out: RAM word 16'h0000 = 8'h3C, hc_visible stepping 1..4 at vc_visible=1 -> pix_data=8'h3C for 4 cycles starting 2 cycles after hc_visible=1; hs_out/vs_out lag hs_in/vs_in by 2.
REQ-038 Out-of-range: wr_addr=16'hC000 in blanking -> wr_ack pulses, mem_we stays 0.
REQ-039 Back-to-back: wr_req held high for 6 blanking cycles -> wr_ack pattern 0,1,0,1,0,1 with mem_we 1,0,1,0,1,0.
